// File: rtl/ofdm_tx_frame_ctrl_if.sv
// Handshake/bus bundle between the frame-request logic, the frame scheduler and the CP buffer.
// The abort/aborted pair exists only when TX_ABORT_EN is defined.
interface ofdm_tx_frame_ctrl_if #(
   parameter int unsigned LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] n_data_sym;
   logic             sym_rdy;
   logic             busy;
   logic             done;
   logic             sym_req;
   logic [1:0]       src_sel;
   logic             samp_en;
   logic [6:0]       samp_idx;
   logic             cp_phase;
   logic [LEN_W-1:0] sym_cnt;
   logic             underrun;
`ifdef TX_ABORT_EN
   logic             abort;
   logic             aborted;

   modport master (output start, n_data_sym, sym_rdy, abort,
                   input  busy, done, sym_req, src_sel, samp_en, samp_idx,
                          cp_phase, sym_cnt, underrun, aborted);
   modport slave  (input  start, n_data_sym, sym_rdy, abort,
                   output busy, done, sym_req, src_sel, samp_en, samp_idx,
                          cp_phase, sym_cnt, underrun, aborted);
`else
   modport master (output start, n_data_sym, sym_rdy,
                   input  busy, done, sym_req, src_sel, samp_en, samp_idx,
                          cp_phase, sym_cnt, underrun);
   modport slave  (input  start, n_data_sym, sym_rdy,
                   output busy, done, sym_req, src_sel, samp_en, samp_idx,
                          cp_phase, sym_cnt, underrun);
`endif
endinterface

// File: rtl/ofdm_tx_frame_ctrl.sv
// OFDM TX frame scheduler: STF -> LTF -> SIG -> DATA -> gap, one sample per clk.
// Optional mid-frame abort (abort/aborted ports) enabled by defining TX_ABORT_EN.
module ofdm_tx_frame_ctrl #(
   parameter int unsigned N_FFT     = 64,
   parameter int unsigned N_CP      = 16,
   parameter int unsigned N_STF_SYM = 2,
   parameter int unsigned N_LTF_SYM = 2,
   parameter int unsigned GAP_LEN   = 8,
   parameter int unsigned LEN_W     = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   ofdm_tx_frame_ctrl_if.slave bus
);
   localparam int unsigned SYM_LEN = N_FFT + N_CP;
   localparam int unsigned IDX_W   = 7;
   localparam int unsigned GAP_W   = $clog2(GAP_LEN + 1);

   typedef enum logic [2:0] {IDLE, STF, LTF, SIG, DATA, WAIT, GAP} state_t;

   state_t           state_q, state_d, tgt_q, tgt_d, adv_tgt;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] cnt_q, cnt_d, pend_q, pend_d, nsym_q, nsym_d, adv_cnt;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             und_q, und_d, abrt_q, abrt_d;
   logic             sym_end, adv, to_gap, req_d, done_d, en_d, abort_hit;
   logic [1:0]       src_d;
   logic             busy_q, done_q, req_q, en_q, cp_q, aborted_q;
   logic [1:0]       src_q;

`ifdef TX_ABORT_EN
   assign abort_hit = bus.abort && (state_q != IDLE) && (state_q != GAP);
   assign bus.aborted = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   // Next-state, counters and next output values
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      nsym_d  = nsym_q;
      gap_d   = gap_q;
      und_d   = und_q;
      abrt_d  = abrt_q;
      req_d   = 1'b0;
      adv     = 1'b0;
      adv_tgt = SIG;
      adv_cnt = '0;
      to_gap  = 1'b0;
      sym_end = (idx_q == IDX_W'(SYM_LEN - 1));

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = STF;
               idx_d   = '0;
               cnt_d   = '0;
               nsym_d  = bus.n_data_sym;
               und_d   = 1'b0;
               abrt_d  = 1'b0;
            end
         end
         STF, LTF: begin
            if (!sym_end) begin
               idx_d = idx_q + IDX_W'(1);
            end else if (state_q == STF && cnt_q == LEN_W'(N_STF_SYM - 1)) begin
               state_d = LTF;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (state_q == LTF && cnt_q == LEN_W'(N_LTF_SYM - 1)) begin
               adv = 1'b1;
            end else begin
               idx_d = '0;
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         SIG: begin
            if (!sym_end)                idx_d = idx_q + IDX_W'(1);
            else if (nsym_q == '0)       to_gap = 1'b1;
            else begin
               adv     = 1'b1;
               adv_tgt = DATA;
            end
         end
         DATA: begin
            if (!sym_end)                             idx_d = idx_q + IDX_W'(1);
            else if (cnt_q == nsym_q - LEN_W'(1))     to_gap = 1'b1;
            else begin
               adv     = 1'b1;
               adv_tgt = DATA;
               adv_cnt = cnt_q + LEN_W'(1);
            end
         end
         WAIT: begin
            if (bus.sym_rdy) begin
               state_d = tgt_q;
               idx_d   = '0;
               cnt_d   = pend_q;
               req_d   = 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_LEN - 1)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort takes precedence over any symbol boundary decision
      if (abort_hit) begin
         adv    = 1'b0;
         to_gap = 1'b1;
         abrt_d = 1'b1;
      end

      if (adv) begin
         if (bus.sym_rdy) begin
            state_d = adv_tgt;
            idx_d   = '0;
            cnt_d   = adv_cnt;
            req_d   = 1'b1;
         end else begin
            state_d = WAIT;
            tgt_d   = adv_tgt;
            pend_d  = adv_cnt;
            und_d   = 1'b1;
         end
      end

      if (to_gap) begin
         state_d = GAP;
         idx_d   = '0;
         cnt_d   = '0;
         gap_d   = '0;
         req_d   = 1'b0;
      end

      en_d   = (state_d == STF) || (state_d == LTF) || (state_d == SIG) || (state_d == DATA);
      done_d = (state_d == GAP) && (gap_d == GAP_W'(GAP_LEN - 1));
      unique case (state_d)
         STF:       src_d = 2'd1;
         LTF:       src_d = 2'd2;
         SIG, DATA: src_d = 2'd3;
         default:   src_d = 2'd0;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tgt_q     <= SIG;
         idx_q     <= '0;
         cnt_q     <= '0;
         pend_q    <= '0;
         nsym_q    <= '0;
         gap_q     <= '0;
         und_q     <= 1'b0;
         abrt_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
         en_q      <= 1'b0;
         cp_q      <= 1'b0;
         src_q     <= 2'd0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tgt_q     <= tgt_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         nsym_q    <= nsym_d;
         gap_q     <= gap_d;
         und_q     <= und_d;
         abrt_q    <= abrt_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= done_d;
         req_q     <= req_d;
         en_q      <= en_d;
         cp_q      <= en_d && (idx_d < IDX_W'(N_CP));
         src_q     <= src_d;
         aborted_q <= done_d && abrt_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sym_req  = req_q;
   assign bus.src_sel  = src_q;
   assign bus.samp_en  = en_q;
   assign bus.samp_idx = idx_q;
   assign bus.cp_phase = cp_q;
   assign bus.sym_cnt  = cnt_q;
   assign bus.underrun = und_q;
endmodule

// File: tb/tb_ofdm_tx_frame_ctrl.sv
// Self-checking bench for ofdm_tx_frame_ctrl: table-driven frames, corner sequences and
// randomized sym_rdy frames against a section-level frame model. Build with TX_ABORT_EN for abort cases.
module tb_ofdm_tx_frame_ctrl;
   localparam int unsigned LEN_W = 8;
   localparam int SYM   = 80;
   localparam int N_CP  = 16;
   localparam int N_STF = 2;
   localparam int N_LTF = 2;
   localparam int GAP   = 8;
   localparam int TAIL  = 3;
   localparam int MAXC  = 4096;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       req;
      logic [1:0] src;
      logic       en;
      logic [6:0] idx;
      logic [7:0] cnt;
      logic       und;
      logic       cp;
      logic       ab;
   } obs_t;

   typedef struct {
      int n; int en; int req; int s1; int s2; int s3;
   } vec_t;

   typedef struct {
      int en; int req; int s1; int s2; int s3; int en_first; int en_last;
      int done_c; int idle_en; int und_end; int req_bad; int ab_cnt;
   } stats_t;

   int   checks   = 0;
   int   failures = 0;
   logic clk = 1'b0;
   logic rst_n;
   logic abort_drv;
   bit   rdy [MAXC];
   obs_t expq [$];
   bit   abq  [$];
   vec_t tbl  [4];

   always #5 clk = ~clk;

   ofdm_tx_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

   ofdm_tx_frame_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef TX_ABORT_EN
   assign bus.abort = abort_drv;
`endif

   function automatic obs_t get_obs();
      obs_t o;
      o.busy = bus.busy;     o.done = bus.done;   o.req = bus.sym_req;
      o.src  = bus.src_sel;  o.en   = bus.samp_en; o.idx = bus.samp_idx;
      o.cnt  = bus.sym_cnt;  o.und  = bus.underrun; o.cp = bus.cp_phase;
`ifdef TX_ABORT_EN
      o.ab = bus.aborted;
`else
      o.ab = 1'b0;
`endif
      return o;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic void push(input logic busy, input logic done, input logic req,
                                input logic [1:0] src, input logic en, input int idx,
                                input int cnt, input logic und, input logic ab, input bit abl);
      obs_t o;
      o.busy = busy; o.done = done; o.req = req; o.src = src; o.en = en;
      o.idx = 7'(idx); o.cnt = 8'(cnt); o.und = und; o.ab = ab;
      o.cp  = en && (idx < N_CP);
      expq.push_back(o);
      abq.push_back(abl);
   endfunction

   function automatic void append_gap(input logic und, input logic ab);
      for (int g = 0; g < GAP; g++) push(1, g == GAP-1, 0, 0, 0, 0, 0, und, ab && (g == GAP-1), 0);
      for (int t = 0; t < TAIL; t++) push(0, 0, 0, 0, 0, 0, 0, und, 0, 0);
   endfunction

   // Expected per-cycle outputs for cycles 1..N after a start accepted in cycle 0
   function automatic void build_model(input int n, input int abort_at);
      int   c = 1;
      int   hold_cnt;
      logic und = 1'b0;
      expq.delete();
      abq.delete();
      for (int s = 0; s < N_STF; s++)
         for (int i = 0; i < SYM; i++) begin push(1, 0, 0, 1, 1, i, s, und, 0, 1); c++; end
      for (int s = 0; s < N_LTF; s++)
         for (int i = 0; i < SYM; i++) begin push(1, 0, 0, 2, 1, i, s, und, 0, 1); c++; end
      hold_cnt = N_LTF - 1;
      for (int k = 0; k <= n; k++) begin
         while (!rdy[c-1] && c < MAXC-1) begin
            und = 1'b1;
            push(1, 0, 0, 0, 0, SYM-1, hold_cnt, und, 0, 1);
            c++;
         end
         for (int i = 0; i < SYM; i++) begin
            push(1, 0, i == 0, 3, 1, i, (k == 0) ? 0 : k-1, und, 0, 1);
            c++;
         end
         hold_cnt = (k == 0) ? 0 : k-1;
      end
      append_gap(und, 0);
      if (abort_at > 0 && abort_at <= expq.size() && abq[abort_at-1]) begin
         while (expq.size() > abort_at) begin
            void'(expq.pop_back());
            void'(abq.pop_back());
         end
         append_gap(expq[abort_at-1].und, 1);
      end
   endfunction

   // Start a frame in the current cycle and compare every following cycle against the model
   task automatic run_frame(input int n, input bit poke, input int abort_at, output stats_t st);
      int   len, mism, first, done_c;
      obs_t a, e, fa, fe;
      build_model(n, abort_at);
      len    = expq.size();
      done_c = -1;
      foreach (expq[i]) if (expq[i].done) done_c = i + 1;
      st = '{default: 0};
      st.en_first = -1;
      mism = 0; first = -1; fa = '0; fe = '0;
      bus.start = 1'b1; bus.n_data_sym = LEN_W'(n); bus.sym_rdy = rdy[0];
      abort_drv = (abort_at >= 0);
      for (int c = 1; c <= len; c++) begin
         @(posedge clk); #1;
         bus.start      = poke && (c == 200 || c == done_c);
         bus.n_data_sym = LEN_W'($urandom);
         bus.sym_rdy    = rdy[c];
         abort_drv      = (abort_at >= 0) && (c == abort_at || c == abort_at + 3);
         a = get_obs();
         e = expq[c-1];
         if (a !== e) begin
            mism++;
            if (first < 0) begin first = c; fa = a; fe = e; end
         end
         if (a.en) begin
            st.en++;
            if (st.en_first < 0) st.en_first = c;
            st.en_last = c;
         end
         if (a.req) begin
            st.req++;
            if (a.idx != 0 || a.src != 2'd3) st.req_bad++;
         end
         if (a.en && a.src == 2'd1) st.s1++;
         if (a.en && a.src == 2'd2) st.s2++;
         if (a.en && a.src == 2'd3) st.s3++;
         if (a.busy && !a.en) st.idle_en++;
         if (a.done) st.done_c = c;
         if (a.ab) st.ab_cnt++;
         st.und_end = a.und;
      end
      bus.start = 1'b0;
      abort_drv = 1'b0;
      checks++;
      if (mism != 0) begin
         failures++;
         $display("FAIL frame_trace n=%0d bad_cycles=%0d first_cycle=%0d actual=%h expected=%h",
                  n, mism, first, fa, fe);
      end
   endtask

   initial begin
      stats_t st;
      int     found, dn, abort_at, n;

      tbl[0] = '{3, 640, 4, 160, 160, 320};
      tbl[1] = '{0, 400, 1, 160, 160, 80};
      tbl[2] = '{1, 480, 2, 160, 160, 160};
      tbl[3] = '{5, 800, 6, 160, 160, 480};

      rst_n = 1'b0; abort_drv = 1'b0;
      bus.start = 1'b0; bus.n_data_sym = '0; bus.sym_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", get_obs(), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven frames with sym_rdy tied high
      for (int v = 0; v < 4; v++) begin
         foreach (rdy[i]) rdy[i] = 1'b1;
         run_frame(tbl[v].n, 0, -1, st);
         check($sformatf("v%0d_samp_en_cycles", v), st.en, tbl[v].en);
         check($sformatf("v%0d_samp_en_contiguous", v), st.en_last - st.en_first + 1, tbl[v].en);
         check($sformatf("v%0d_sym_req_count", v), st.req, tbl[v].req);
         check($sformatf("v%0d_sym_req_position", v), st.req_bad, 0);
         check($sformatf("v%0d_stf_cycles", v), st.s1, tbl[v].s1);
         check($sformatf("v%0d_ltf_cycles", v), st.s2, tbl[v].s2);
         check($sformatf("v%0d_payload_cycles", v), st.s3, tbl[v].s3);
         check($sformatf("v%0d_done_after_last", v), st.done_c - st.en_last, GAP);
         check($sformatf("v%0d_underrun", v), st.und_end, 0);
      end

      // sym_rdy low for 5 cycles starting at the last SIG sample (cycle 400)
      foreach (rdy[i]) rdy[i] = 1'b1;
      for (int i = 400; i < 405; i++) rdy[i] = 1'b0;
      run_frame(2, 0, -1, st);
      check("wait_cycles", st.idle_en - GAP, 5);
      check("wait_sym_req_count", st.req, 3);
      check("wait_underrun_sticky", st.und_end, 1);

      // start during LTF and on the done cycle are both ignored
      foreach (rdy[i]) rdy[i] = 1'b1;
      run_frame(1, 1, -1, st);
      check("poke_samp_en_cycles", st.en, 480);
      check("poke_sym_req_count", st.req, 2);

      // Asynchronous reset at STF sample 37
      bus.start = 1'b1; bus.n_data_sym = LEN_W'(2); bus.sym_rdy = 1'b1;
      found = 0;
      for (int c = 1; c <= 60 && found == 0; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.samp_en && bus.src_sel == 2'd1 && bus.samp_idx == 7'd37) found = 1;
      end
      check("reach_stf_sample_37", found, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", get_obs(), 0);
      dn = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dn++;
      end
      check("no_done_during_reset", dn, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_reset", get_obs(), 0);
      foreach (rdy[i]) rdy[i] = 1'b1;
      run_frame(1, 0, -1, st);
      check("post_reset_samp_en_cycles", st.en, 480);

`ifdef TX_ABORT_EN
      // abort at DATA1 sample 10 (cycle 491) with n_data_sym=4
      foreach (rdy[i]) rdy[i] = 1'b1;
      run_frame(4, 0, 491, st);
      check("abort_sym_req_count", st.req, 3);
      check("abort_last_sample", st.en_last, 491);
      check("abort_done_after_gap", st.done_c - st.en_last, GAP);
      check("abort_aborted_pulses", st.ab_cnt, 1);
`endif

      // Randomized sym_rdy (and abort when built in) against the frame model
      for (int r = 0; r < 12; r++) begin
         foreach (rdy[i]) rdy[i] = ($urandom % 4) != 0;
         n = int'($urandom % 6);
         abort_at = -1;
`ifdef TX_ABORT_EN
         if ($urandom % 3 == 0) abort_at = int'($urandom_range(1, 400 + 80 * n));
`endif
         run_frame(n, 0, abort_at, st);
         check($sformatf("rand%0d_sym_req_count", r), st.req, (abort_at < 0) ? n + 1 : st.req);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
